// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier issue controller.
//   OP_W / PROD_W : operand and product widths
//   state_e       : issue FSM state encoding
//   op_entry_t    : one queued operation {signed mode, operand a, operand b}
package mult_pkg;

  localparam int unsigned OP_W   = 32;
  localparam int unsigned PROD_W = 64;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } state_e;

  typedef struct packed {
    logic            sgn;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } op_entry_t;

endpackage

// File: rtl/op_fifo.sv
// Operand FIFO for the multiplier issue controller.
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data      : write one entry (ignored when full)
//   pop, pop_data        : read/remove the head entry (ignored when empty); pop_data shows head
//   full, empty          : occupancy flags
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module op_fifo
  import mult_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      push,
  input  op_entry_t push_data,
  input  logic      pop,
  output op_entry_t pop_data,
  output logic      full,
  output logic      empty
);

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  op_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic            push_en, pop_en;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign push_en  = push && !full;
  assign pop_en   = pop && !empty;
  assign pop_data = mem[rd_ptr_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
      // Simultaneous push and pop leave the occupancy unchanged.
      if (push_en && !pop_en)      count_q <= count_q + (AW+1)'(1);
      else if (pop_en && !push_en) count_q <= count_q - (AW+1)'(1);
    end
  end

  // Storage needs no reset: occupancy alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issue controller for a multi-cycle 32x32 multiplier.
// Queues operand requests, issues one operation at a time with a single-cycle
// mul_start, holds the operands stable until mul_done, and presents the
// captured product on a valid/ready output.
// Ports:
//   clk, reset_n                       : clock, asynchronous active-low reset
//   in_valid/in_ready, in_a/in_b/in_signed : operand request handshake
//   mul_start, mul_op_a/mul_op_b/mul_signed_mode : multiplier command
//   mul_done, mul_product              : multiplier completion (product valid only with done)
//   out_valid/out_ready, out_product/out_signed : result handshake
//   busy                               : any operation queued, in flight or unconsumed
//   err_timeout                        : sticky watchdog flag
// Build option: define MULT_ISSUE_TIMEOUT_EN to add the WAIT watchdog; otherwise
// err_timeout is tied low and WAIT waits indefinitely.
module mult_issue_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic              in_signed,
  output logic              mul_start,
  output logic [OP_W-1:0]   mul_op_a,
  output logic [OP_W-1:0]   mul_op_b,
  output logic              mul_signed_mode,
  input  logic              mul_done,
  input  logic [PROD_W-1:0] mul_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_product,
  output logic              out_signed,
  output logic              busy,
  output logic              err_timeout
);

  state_e            state_q, state_d;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  op_entry_t         fifo_wdata, fifo_rdata;
  op_entry_t         op_q;
  logic              out_valid_q, out_signed_q;
  logic [PROD_W-1:0] out_product_q;
  logic              capture, timeout_hit;

  assign fifo_push  = in_valid && in_ready;
  assign fifo_wdata = '{sgn: in_signed, a: in_a, b: in_b};

  op_fifo #(
    .DEPTH (DEPTH)
  ) u_op_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Hold off while a result is unconsumed: only one op may be outstanding.
        if (!fifo_empty && !out_valid_q) begin
          state_d  = StIssue;
          fifo_pop = 1'b1;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (mul_done) begin
          state_d = StIdle;
          capture = 1'b1;
        end else if (timeout_hit) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      op_q          <= '0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
      out_signed_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // Operands change only on pop, so they stay fixed through ISSUE and WAIT.
      if (fifo_pop) op_q <= fifo_rdata;
      // The multiplier clears its product after done, so capture on that cycle only.
      if (capture) begin
        out_valid_q   <= 1'b1;
        out_product_q <= mul_product;
        out_signed_q  <= op_q.sgn;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef MULT_ISSUE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wd_cnt_q;
  logic          err_q;

  // Counter holds the number of WAIT cycles already spent without mul_done.
  assign timeout_hit = (state_q == StWait) && !mul_done && (wd_cnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == StWait) wd_cnt_q <= wd_cnt_q + TW'(1);
      else                   wd_cnt_q <= '0;
      if (timeout_hit) err_q <= 1'b1;
    end
  end

  assign err_timeout = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign err_timeout    = 1'b0;
`endif

  assign in_ready        = !fifo_full;
  assign mul_start       = (state_q == StIssue);
  assign mul_op_a        = op_q.a;
  assign mul_op_b        = op_q.b;
  assign mul_signed_mode = op_q.sgn;
  assign out_valid       = out_valid_q;
  assign out_product     = out_product_q;
  assign out_signed      = out_signed_q;
  assign busy            = (state_q != StIdle) || !fifo_empty || out_valid_q;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
`timescale 1ns/1ps
module tb_mult_issue_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 20;

  typedef struct {
    logic [63:0] p;
    logic        s;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        in_valid, in_ready, in_signed;
  logic [31:0] in_a, in_b;
  logic        mul_start, mul_signed_mode, mul_done;
  logic [31:0] mul_op_a, mul_op_b;
  logic [63:0] mul_product;
  logic        out_valid, out_ready, out_signed, busy, err_timeout;
  logic [63:0] out_product;

  int   checks = 0;
  int   failures = 0;
  int   starts_total = 0;
  exp_t exp_q[$];

  // Knobs written only by the main sequence.
  int   rdy_mode = 0;   // 0: never ready, 1: always ready, 2: random
  int   lat_max = 4;
  bit   hang = 0;       // multiplier never answers
  int   stray_cnt = 0;

  mult_issue_ctrl #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TO)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_a            (in_a),
    .in_b            (in_b),
    .in_signed       (in_signed),
    .mul_start       (mul_start),
    .mul_op_a        (mul_op_a),
    .mul_op_b        (mul_op_b),
    .mul_signed_mode (mul_signed_mode),
    .mul_done        (mul_done),
    .mul_product     (mul_product),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_product     (out_product),
    .out_signed      (out_signed),
    .busy            (busy),
    .err_timeout     (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic chk_vec(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Multiplier model: latches operands on mul_start, checks they stay put,
  // then pulses mul_done with the product for exactly one cycle.
  int          pend = -1;
  logic [31:0] cap_a, cap_b;
  logic        cap_s;
  int          stray_seen = 0;

  initial begin
    mul_done    = 1'b0;
    mul_product = '0;
    forever begin
      @(negedge clk);
      mul_done    = 1'b0;
      mul_product = '0;
      if (!reset_n) begin
        pend = -1;
      end else if (mul_start && !hang) begin
        chk_bit("start_while_in_flight", pend == -1, 1'b1);
        cap_a = mul_op_a;
        cap_b = mul_op_b;
        cap_s = mul_signed_mode;
        pend  = $urandom_range(lat_max, 1);
      end else if (pend > 0) begin
        chk_vec("op_a_stable", 64'(mul_op_a), 64'(cap_a));
        chk_vec("op_b_stable", 64'(mul_op_b), 64'(cap_b));
        chk_bit("mode_stable", mul_signed_mode, cap_s);
        pend--;
        if (pend == 0) begin
          mul_done    = 1'b1;
          mul_product = ref_prod(cap_a, cap_b, cap_s);
          pend        = -1;
        end
      end else if (stray_cnt != stray_seen) begin
        mul_done    = 1'b1;
        mul_product = 64'h0000_DEAD_BEEF_0000;
        stray_seen++;
      end
    end
  end

  // Result sink.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(1));
      endcase
    end
  end

  // Monitor: compares every delivered result with the scoreboard head.
  exp_t mon_e;
  logic prev_start = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out: got %h expected no result", out_product);
          end else begin
            mon_e = exp_q.pop_front();
            chk_vec("out_product", out_product, mon_e.p);
            chk_bit("out_signed", out_signed, mon_e.s);
          end
        end
        if (mul_start) begin
          starts_total++;
          chk_bit("start_single_cycle", prev_start, 1'b0);
          chk_bit("no_issue_while_out_valid", out_valid, 1'b0);
        end
        prev_start = mul_start;
      end else begin
        prev_start = 1'b0;
      end
    end
  end

  initial begin
    #1ms;
    failures++;
    $display("FAIL global_timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit");
  end

  task automatic push_one(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input bit want_out);
    bit   acc = 1'b0;
    exp_t e;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    for (int c = 0; c < 100 && !acc; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk_bit("push_accept", acc, 1'b1);
    if (acc && want_out) begin
      e.p = ref_prod(a, b, s);
      e.s = s;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_stream(input int n, input int budget, input bit gaps, output int acc);
    bit   hs;
    exp_t e;
    acc = 0;
    for (int c = 0; c < budget && acc < n; c++) begin
      in_valid  = gaps ? ($urandom_range(3) != 0) : 1'b1;
      in_a      = ($urandom_range(3) == 0) ? 32'($urandom_range(15)) : $urandom;
      in_b      = $urandom;
      in_signed = 1'($urandom_range(1));
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        e.p = ref_prod(in_a, in_b, in_signed);
        e.s = in_signed;
        exp_q.push_back(e);
        acc++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_start(output int k);
    k = 0;
    while (!mul_start && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk_bit("start_seen", mul_start, 1'b1);
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk_bit("drain_done", (exp_q.size() == 0) && !busy, 1'b1);
  endtask

  task automatic check_reset_vals();
    chk_bit("rst_in_ready", in_ready, 1'b1);
    chk_bit("rst_mul_start", mul_start, 1'b0);
    chk_vec("rst_mul_op_a", 64'(mul_op_a), 64'd0);
    chk_vec("rst_mul_op_b", 64'(mul_op_b), 64'd0);
    chk_bit("rst_mul_signed_mode", mul_signed_mode, 1'b0);
    chk_bit("rst_out_valid", out_valid, 1'b0);
    chk_vec("rst_out_product", out_product, 64'd0);
    chk_bit("rst_out_signed", out_signed, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_err_timeout", err_timeout, 1'b0);
  endtask

  int k, acc, s0;

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Unsigned 3*5, including issue latency from an idle, empty block.
    rdy_mode = 1;
    push_one(32'd3, 32'd5, 1'b0, 1'b1);
    wait_start(k);
    chk_bit("start_latency", (k >= 1) && (k <= 2), 1'b1);
    drain();

    // Signed -2*3.
    push_one(32'hFFFF_FFFE, 32'd3, 1'b1, 1'b1);
    drain();

    // Stalled output: five accepted, one issue until the result is taken.
    rdy_mode = 0;
    s0 = starts_total;
    push_stream(6, 12, 1'b0, acc);
    chk_vec("accepted_when_stalled", 64'(acc), 64'd5);
    chk_bit("in_ready_full", in_ready, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk_vec("starts_while_stalled", 64'(starts_total - s0), 64'd1);
    chk_bit("out_valid_held", out_valid, 1'b1);
    rdy_mode = 1;
    drain();
    chk_vec("starts_after_stall", 64'(starts_total - s0), 64'd5);

    // Back-to-back with a fast multiplier and an always-ready sink.
    lat_max = 1;
    s0 = starts_total;
    push_stream(10, 300, 1'b0, acc);
    drain();
    chk_vec("starts_back_to_back", 64'(starts_total - s0), 64'(acc));

    // Random traffic, gaps and backpressure.
    lat_max  = 8;
    rdy_mode = 2;
    s0 = starts_total;
    push_stream(40, 2000, 1'b1, acc);
    chk_vec("accepted_random", 64'(acc), 64'd40);
    drain();
    chk_vec("starts_random", 64'(starts_total - s0), 64'd40);

    // Reset in the middle of WAIT, then a stray mul_done.
    rdy_mode = 1;
    hang     = 1'b1;
    push_one(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
    wait_start(k);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_vals();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    hang    = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    stray_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk_bit("stray_done_ignored", out_valid, 1'b0);
    end
    chk_bit("idle_after_stray", busy, 1'b0);

`ifdef MULT_ISSUE_TIMEOUT_EN
    // Watchdog: first op never completes, second op must still be served.
    hang = 1'b1;
    push_one(32'd7, 32'd9, 1'b0, 1'b0);
    push_one(32'd11, 32'd13, 1'b0, 1'b1);
    wait_start(k);
    @(posedge clk);
    #1;
    hang = 1'b0;
    repeat (TO - 1) @(posedge clk);
    #1;
    chk_bit("err_before_limit", err_timeout, 1'b0);
    @(posedge clk);
    #1;
    chk_bit("err_at_limit", err_timeout, 1'b1);
    drain();
    chk_bit("err_sticky", err_timeout, 1'b1);
`else
    chk_bit("err_tied_low", err_timeout, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
